pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 32: cycles the PLL resets are held in RESET_PLLS.
REQ-002 SHALL have parameter LOCK_FILTER, default 16: consecutive synchronized-high lock samples required before a lock counts as filtered-high.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 270000: maximum cycles spent in any one wait state (10 ms at 27 MHz).
REQ-004 SHALL have parameter STAGE_DELAY, default 256: cycles between successive domain-reset releases.
REQ-005 SHALL have parameter MAX_RETRY, default 7: number of failures tolerated before FAULT.
REQ-006 SHALL have port clk_27m, input, 1 bit: the only clock; all logic runs on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port pll_lock, input, 5 bits, asynchronous lock signals indexed 0=video, 1=video_x5, 2=system, 3=audio, 4=sdram.
REQ-009 SHALL have port pll_reset, output, 5 bits: per-PLL reset, high means held in reset, same indexing as pll_lock.
REQ-010 SHALL have port domain_reset, output, 5 bits: per-clock-domain reset, high means asserted, same indexing.
REQ-011 SHALL have port all_locked, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port retry_count, output, 3 bits: count of failures so far.
REQ-013 SHALL have port fault, output, 1 bit: high only in state FAULT.

Function
REQ-014 Each pll_lock bit SHALL pass through a 2-flop synchronizer.
REQ-015 Each bit SHALL have a filter counter that increments while the synchronized bit is 1, saturating at LOCK_FILTER; the bit is filtered-high when the counter equals LOCK_FILTER; a single 0 sample SHALL clear the counter in the same cycle.
REQ-016 The state machine SHALL have the states RESET_PLLS, WAIT_BASE, WAIT_X5, STAGE, RUN and FAULT; all outputs are registered.
REQ-017 RESET_PLLS: pll_reset=5'b11111, domain_reset=5'b11111; after PLL_RST_CYCLES cycles -> WAIT_BASE.
REQ-018 WAIT_BASE: pll_reset=5'b00010, so the video_x5 PLL stays in reset because its input clock comes from the video PLL; when filtered[0] -> WAIT_X5.
REQ-019 WAIT_X5: pll_reset=5'b00000; when filtered==5'b11111 -> STAGE with stage index 0.
REQ-020 Each wait state SHALL have its own timeout counter, cleared on entry; reaching LOCK_TIMEOUT is a failure.
REQ-021 STAGE SHALL deassert domain_reset in the order 4, 2, 3, 0, 1, one bit each time STAGE_DELAY cycles elapse; after bit 1 is released -> RUN.
REQ-022 In STAGE and RUN, a 0 on any filtered bit SHALL be a failure.
REQ-023 On a failure: if retry_count < MAX_RETRY, increment retry_count and go to RESET_PLLS; otherwise go to FAULT with retry_count unchanged.
REQ-024 domain_reset SHALL return to 5'b11111 on the clock edge that registers the failure transition.
REQ-025 FAULT SHALL be terminal until reset: pll_reset=5'b11111, domain_reset=5'b11111, fault=1.
REQ-026 If a timeout and a lock loss occur in the same cycle, they SHALL count as a single failure (one increment).
REQ-027 retry_count SHALL be cleared only by reset; reaching RUN does not clear it.
REQ-028 Lock glitches shorter than LOCK_FILTER during the wait states SHALL only delay progress and SHALL NOT count as failures.

Reset
REQ-029 While reset=1 at a clock edge: state=RESET_PLLS, all counters=0, synchronizers=0, pll_reset=5'b11111, domain_reset=5'b11111, all_locked=0, fault=0, retry_count=0.
REQ-030 Reset asserted in any state, including FAULT and mid-STAGE, SHALL restart the full sequence on the first edge after reset is deasserted.

Verification (PLL_RST_CYCLES=8, LOCK_FILTER=4, LOCK_TIMEOUT=100, STAGE_DELAY=10, MAX_RETRY=2)
REQ-031 Nominal: release reset, then drive pll_lock=5'b11101 once pll_reset becomes 5'b00010 and set bit 1 high once pll_reset becomes 0 -> domain_reset steps 11111 -> 01111 -> 01011 -> 00011 -> 00010 -> 00000, 10 cycles apart; all_locked=1; retry_count=0.
REQ-032 Ordering: hold pll_lock[0]=0 for 50 cycles -> pll_reset[1] stays 1 throughout, no failure, retry_count=0.
REQ-033 Timeout: hold pll_lock=0 -> after 8+100 cycles, back to RESET_PLLS with retry_count=1; after three timeouts fault=1 and retry_count=2.
REQ-034 Loss in RUN: drop pll_lock[3] for 1 cycle -> domain_reset=5'b11111 within 2 synchronizer cycles + 1; all_locked=0; retry_count increments.
REQ-035 Glitch in WAIT_X5: pulse one lock bit low for 2 cycles -> no failure; STAGE is entered 4 filter cycles later.
REQ-036 Reset in FAULT or mid-STAGE -> outputs match REQ-029 on the next edge, and the nominal sequence then completes.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Brings up five PLLs in dependency order, then releases the clock-domain resets one
// by one. Lock inputs are synchronized and debounced; failures retry up to MAX_RETRY.
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 32,
    parameter int unsigned LOCK_FILTER    = 16,
    parameter int unsigned LOCK_TIMEOUT   = 270000,
    parameter int unsigned STAGE_DELAY    = 256,
    parameter int unsigned MAX_RETRY      = 7
) (
    input  logic       clk_27m,
    input  logic       reset,
    input  logic [4:0] pll_lock,
    output logic [4:0] pll_reset,
    output logic [4:0] domain_reset,
    output logic       all_locked,
    output logic [2:0] retry_count,
    output logic       fault
);

    localparam int unsigned CntMax0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned CntMax  = (CntMax0 > STAGE_DELAY) ? CntMax0 : STAGE_DELAY;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned FiltW   = $clog2(LOCK_FILTER + 1);

    localparam logic [CntW-1:0]  RstLast   = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0]  ToLast    = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]  StageLast = CntW'(STAGE_DELAY - 1);
    localparam logic [FiltW-1:0] FiltMax   = FiltW'(LOCK_FILTER);
    localparam logic [2:0]       RetryMax  = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        StResetPlls,
        StWaitBase,
        StWaitX5,
        StStage,
        StRun,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       stage_q, stage_d;
    logic [2:0]       retry_q, retry_d;
    logic [4:0]       pll_reset_q, pll_reset_d;
    logic [4:0]       domain_q, domain_d;
    logic             all_locked_q, all_locked_d;
    logic             fault_q, fault_d;
    logic [4:0]       sync1_q, sync2_q;
    logic [FiltW-1:0] filt_q [5];
    logic [FiltW-1:0] filt_d [5];
    logic [4:0]       filtered;
    logic [4:0]       release_mask;
    logic             fail;

    // A zero sample drops filtered in the same cycle, before the counter clears.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            filtered[i] = sync2_q[i] && (filt_q[i] == FiltMax);
            if (!sync2_q[i]) begin
                filt_d[i] = '0;
            end else if (filt_q[i] != FiltMax) begin
                filt_d[i] = filt_q[i] + FiltW'(1);
            end else begin
                filt_d[i] = filt_q[i];
            end
        end
    end

    // Release order 4, 2, 3, 0, 1.
    always_comb begin
        case (stage_q)
            3'd0:    release_mask = 5'b10000;
            3'd1:    release_mask = 5'b00100;
            3'd2:    release_mask = 5'b01000;
            3'd3:    release_mask = 5'b00001;
            3'd4:    release_mask = 5'b00010;
            default: release_mask = 5'b00000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        stage_d  = stage_q;
        retry_d  = retry_q;
        domain_d = domain_q;
        fail     = 1'b0;

        unique case (state_q)
            StResetPlls: begin
                domain_d = 5'b11111;
                if (cnt_q == RstLast) begin
                    state_d = StWaitBase;
                    cnt_d   = '0;
                end
            end
            StWaitBase: begin
                if (filtered[0]) begin
                    state_d = StWaitX5;
                    cnt_d   = '0;
                end else if (cnt_q == ToLast) begin
                    fail = 1'b1;
                end
            end
            StWaitX5: begin
                if (&filtered) begin
                    state_d = StStage;
                    cnt_d   = '0;
                    stage_d = 3'd0;
                end else if (cnt_q == ToLast) begin
                    fail = 1'b1;
                end
            end
            StStage: begin
                if (!(&filtered)) begin
                    fail = 1'b1;
                end else if (cnt_q == StageLast) begin
                    cnt_d    = '0;
                    domain_d = domain_q & ~release_mask;
                    if (stage_q == 3'd4) begin
                        state_d = StRun;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q;
                if (!(&filtered)) begin
                    fail = 1'b1;
                end
            end
            StFault: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = StResetPlls;
                cnt_d   = '0;
            end
        endcase

        // One failure per cycle regardless of how many causes coincide.
        if (fail) begin
            cnt_d    = '0;
            domain_d = 5'b11111;
            if (retry_q < RetryMax) begin
                retry_d = retry_q + 3'd1;
                state_d = StResetPlls;
            end else begin
                state_d = StFault;
            end
        end
    end

    always_comb begin
        case (state_d)
            StWaitBase:             pll_reset_d = 5'b00010;
            StWaitX5, StStage, StRun: pll_reset_d = 5'b00000;
            default:                pll_reset_d = 5'b11111;
        endcase
        all_locked_d = (state_d == StRun);
        fault_d      = (state_d == StFault);
    end

    always_ff @(posedge clk_27m) begin
        if (reset) begin
            state_q      <= StResetPlls;
            cnt_q        <= '0;
            stage_q      <= '0;
            retry_q      <= '0;
            pll_reset_q  <= 5'b11111;
            domain_q     <= 5'b11111;
            all_locked_q <= 1'b0;
            fault_q      <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            for (int i = 0; i < 5; i++) begin
                filt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            retry_q      <= retry_d;
            pll_reset_q  <= pll_reset_d;
            domain_q     <= domain_d;
            all_locked_q <= all_locked_d;
            fault_q      <= fault_d;
            sync1_q      <= pll_lock;
            sync2_q      <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                filt_q[i] <= filt_d[i];
            end
        end
    end

    assign pll_reset    = pll_reset_q;
    assign domain_reset = domain_q;
    assign all_locked   = all_locked_q;
    assign retry_count  = retry_q;
    assign fault        = fault_q;

endmodule
